// File: rtl/pixel_sched_pkg.sv
// Shared types, raster predicates and framing constants for the pixel frame scheduler.
package pixel_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    LAUNCH,
    WAIT_BUSY,
    STREAM,
    DONE
  } state_t;

  localparam logic [15:0] SOF_WORD = 16'hEAFF;
  localparam logic [15:0] EOF_WORD = 16'hDDAA;

  // Generator's end-of-data point: last active column on the first blanking line.
  function automatic logic frame_tick_f(input logic [9:0] x, input logic [9:0] y,
                                        input int unsigned h, input int unsigned v);
    return (32'(x) == h - 1) && (32'(y) == v);
  endfunction

  function automatic logic launch_window_f(input logic [9:0] y, input int unsigned v);
    return 32'(y) >= v;
  endfunction

endpackage

// File: rtl/pixel_rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr+1 upward, wrapping at NREQ.
module pixel_rr_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  always_comb begin
    logic        found;
    int unsigned j;
    found   = 1'b0;
    j       = 0;
    o_grant = '0;
    o_idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      j = (32'(i_ptr) + k) % NREQ;
      if (!found && i_req[j]) begin
        found      = 1'b1;
        o_grant[j] = 1'b1;
        o_idx      = IW'(j);
      end
    end
    o_any = found;
  end

endmodule

// File: rtl/pixel_frame_scheduler.sv
// Shares one MIPI payload generator between NREQ requesters, launching only in blanking.
// Optional empty keep-alive frames are enabled by defining PIXEL_SCHED_KEEPALIVE_EN.
module pixel_frame_scheduler #(
  parameter int unsigned DLEN             = 43,
  parameter int unsigned NREQ             = 3,
  parameter int unsigned activeVideo_h    = 640,
  parameter int unsigned activeVideo_v    = 480,
  parameter int unsigned TIMEOUT_FRAMES   = 4,
  parameter int unsigned KEEPALIVE_FRAMES = 8
) (
  input  logic                   tx_pixel_clk,
  input  logic                   rst,
  input  logic [9:0]             x,
  input  logic [9:0]             y,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DLEN*8-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        req_done,
  input  logic                   gen_busy,
  output logic [DLEN*8-1:0]      gen_data,
  output logic                   gen_data_available,
  output logic                   gen_write_enable,
  output logic [15:0]            frame_count,
  output logic                   err_timeout
);
  import pixel_sched_pkg::*;

  localparam int unsigned PW = DLEN * 8;
  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned TW = $clog2(TIMEOUT_FRAMES + 1);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_FRAMES < 1 || KEEPALIVE_FRAMES < 1) begin : g_bad_cfg
    $error("pixel_frame_scheduler: unsupported parameter set");
  end

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_ptr, r_win, w_arb_idx;
  logic [NREQ-1:0] r_win_1h, w_arb_grant;
  logic            w_arb_any, w_tick, w_window, w_ka_due, w_ka_active;
  logic [PW-1:0]   r_gen_data, w_slice;
  logic [TW-1:0]   r_to_cnt;
  logic [15:0]     r_frame_count;
  logic            r_err;

  assign w_tick   = frame_tick_f(x, y, activeVideo_h, activeVideo_v);
  assign w_window = launch_window_f(y, activeVideo_v);

  pixel_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_any   (w_arb_any)
  );

  always_comb begin
    w_slice = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (r_win == IW'(i)) w_slice = req_data[i*PW +: PW];
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    req_ready          = '0;
    req_done           = '0;
    gen_data_available = 1'b0;
    gen_write_enable   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!gen_busy && w_window) begin
          if (w_arb_any)     w_state_nxt = GRANT;
          else if (w_ka_due) w_state_nxt = LAUNCH;
        end
      end
      GRANT: begin
        req_ready   = r_win_1h;
        w_state_nxt = LAUNCH;
      end
      LAUNCH: begin
        gen_data_available = !w_ka_active;
        gen_write_enable   = w_ka_active;
        w_state_nxt        = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // A busy rise outranks a coincident frame_tick.
        if (gen_busy) w_state_nxt = STREAM;
        else if (w_tick && r_to_cnt == TW'(TIMEOUT_FRAMES - 1)) w_state_nxt = IDLE;
      end
      STREAM: begin
        if (!gen_busy) w_state_nxt = DONE;
      end
      DONE: begin
        req_done    = w_ka_active ? '0 : r_win_1h;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge tx_pixel_clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_ptr         <= IW'(NREQ - 1);
      r_win         <= '0;
      r_win_1h      <= '0;
      r_gen_data    <= '0;
      r_to_cnt      <= '0;
      r_frame_count <= '0;
      r_err         <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_state_nxt == GRANT) begin
        r_win    <= w_arb_idx;
        r_win_1h <= w_arb_grant;
      end
      if (r_state == GRANT) begin
        r_gen_data <= w_slice;
        r_ptr      <= r_win;
      end
      if (r_state == LAUNCH) r_to_cnt <= '0;
      if (r_state == WAIT_BUSY && !gen_busy && w_tick) begin
        r_to_cnt <= r_to_cnt + 1'b1;
        if (r_to_cnt == TW'(TIMEOUT_FRAMES - 1)) r_err <= 1'b1;
      end
      if (r_state == DONE && !w_ka_active) r_frame_count <= r_frame_count + 1'b1;
    end
  end

`ifdef PIXEL_SCHED_KEEPALIVE_EN
  localparam int unsigned KW = $clog2(KEEPALIVE_FRAMES + 1);
  logic [KW-1:0] r_idle_cnt;
  logic          r_ka;

  assign w_ka_due    = (r_idle_cnt == KW'(KEEPALIVE_FRAMES));
  assign w_ka_active = r_ka;

  always_ff @(posedge tx_pixel_clk) begin
    if (rst) begin
      r_idle_cnt <= '0;
      r_ka       <= 1'b0;
    end else if (r_state == IDLE && w_state_nxt == GRANT) begin
      r_idle_cnt <= '0;
      r_ka       <= 1'b0;
    end else if (r_state == IDLE && w_state_nxt == LAUNCH) begin
      r_idle_cnt <= '0;
      r_ka       <= 1'b1;
    end else if (r_state == IDLE && req_valid == '0 && w_tick && !w_ka_due) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end
`else
  assign w_ka_due    = 1'b0;
  assign w_ka_active = 1'b0;
`endif

  assign gen_data    = r_gen_data;
  assign frame_count = r_frame_count;
  assign err_timeout = r_err;

endmodule

// File: tb/tb_pixel_frame_scheduler.sv
// Directed bench for pixel_frame_scheduler: cycle table for one transaction plus corner sequences.
module tb_pixel_frame_scheduler;
  localparam int unsigned DLEN = 43;
  localparam int unsigned NREQ = 3;
  localparam int unsigned PW   = DLEN * 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [9:0]           x, y;
  logic [NREQ-1:0]      rv;
  logic [NREQ*PW-1:0]   rd;
  logic [NREQ-1:0]      rdy, done;
  logic                 busy;
  logic [PW-1:0]        gd;
  logic                 gda, gwe;
  logic [15:0]          fc;
  logic                 err;

  int n_checks = 0;
  int n_err    = 0;
  int gwe_cnt  = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  pixel_frame_scheduler #(.DLEN(DLEN), .NREQ(NREQ)) dut (
    .tx_pixel_clk       (clk),
    .rst                (rst),
    .x                  (x),
    .y                  (y),
    .req_valid          (rv),
    .req_data           (rd),
    .req_ready          (rdy),
    .req_done           (done),
    .gen_busy           (busy),
    .gen_data           (gd),
    .gen_data_available (gda),
    .gen_write_enable   (gwe),
    .frame_count        (fc),
    .err_timeout        (err)
  );

  always @(negedge clk) begin
    if (gwe) gwe_cnt++;
    if (done != '0) done_cnt++;
  end

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  rv;
    logic        busy;
    logic [2:0]  e_rdy;
    logic        e_gda;
    logic [2:0]  e_done;
    logic [15:0] e_fc;
  } vec_t;

  vec_t tbl [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] slice(input int unsigned i);
    return rd[i*PW +: PW];
  endfunction

  task automatic chk_data(input string nm, input int unsigned i);
    logic [PW-1:0] e;
    e = slice(i);
    n_checks++;
    if (gd !== e) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, gd, e);
    end
  endtask

  task automatic ftick();
    x = 10'd639; y = 10'd480; tick();
    x = 10'd0;   y = 10'd0;   tick();
  endtask

  // Opens the window, waits (bounded) for the grant, then steps through LAUNCH into WAIT_BUSY.
  task automatic launch_to_wait(input int unsigned idx);
    int n;
    x = 10'd0; y = 10'd480; busy = 1'b0;
    n = 0;
    while (rdy == '0 && n < 8) begin
      tick();
      n++;
    end
    chk("grant", 32'(rdy), 32'(1) << idx);
    tick();
    chk("launch_pulse", 32'(gda), 32'd1);
    chk_data("gen_data", idx);
    tick();
  endtask

  task automatic finish_frame(input int unsigned idx);
    busy = 1'b1; y = 10'd0;
    tick();
    tick();
    busy = 1'b0;
    tick();
    chk("done", 32'(done), 32'(1) << idx);
    tick();
  endtask

  task automatic serve(input int unsigned idx);
    launch_to_wait(idx);
    finish_frame(idx);
  endtask

  initial begin
    logic [NREQ-1:0] seen;
    int              d0;

    for (int unsigned i = 0; i < NREQ; i++)
      for (int unsigned b = 0; b < DLEN; b++)
        rd[i*PW + b*8 +: 8] = 8'((i << 6) + b + 1);

    tbl[0] = '{10'd0, 10'd480, 3'b001, 1'b0, 3'b001, 1'b0, 3'b000, 16'd0};
    tbl[1] = '{10'd0, 10'd480, 3'b000, 1'b0, 3'b000, 1'b1, 3'b000, 16'd0};
    tbl[2] = '{10'd0, 10'd481, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 16'd0};
    tbl[3] = '{10'd0, 10'd0,   3'b000, 1'b1, 3'b000, 1'b0, 3'b000, 16'd0};
    tbl[4] = '{10'd5, 10'd100, 3'b010, 1'b1, 3'b000, 1'b0, 3'b000, 16'd0};
    tbl[5] = '{10'd0, 10'd200, 3'b000, 1'b0, 3'b000, 1'b0, 3'b001, 16'd0};
    tbl[6] = '{10'd0, 10'd200, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000, 16'd1};

    rst = 1'b1; x = '0; y = '0; rv = '0; busy = 1'b0;
    tick();
    tick();
    chk("rst_ready", 32'(rdy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_gda", 32'(gda), 32'd0);
    chk("rst_gwe", 32'(gwe), 32'd0);
    chk("rst_fc", 32'(fc), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_gen_data", 32'(gd == '0), 32'd1);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      x = tbl[i].x; y = tbl[i].y; rv = tbl[i].rv; busy = tbl[i].busy;
      tick();
      chk($sformatf("tbl%0d_ready", i), 32'(rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_gda", i), 32'(gda), 32'(tbl[i].e_gda));
      chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].e_done));
      chk($sformatf("tbl%0d_fc", i), 32'(fc), 32'(tbl[i].e_fc));
      if (i == 1) chk_data("tbl_gen_data", 0);
    end
    chk_data("gen_data_hold", 0);

    // Contention right after reset: order 0,1,2.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    rv = 3'b111;
    serve(0);
    serve(1);
    serve(2);
    chk("contention_fc", 32'(fc), 32'd3);
    rv = '0;

    // Mid-frame request waits for blanking.
    rv = 3'b001; x = 10'd0; y = 10'd100; seen = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen |= rdy;
    end
    chk("midframe_no_grant", 32'(seen), 32'd0);
    serve(0);
    rv = '0;

    // Generator already busy in IDLE: hold.
    rv = 3'b010; x = 10'd0; y = 10'd480; busy = 1'b1; seen = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen |= rdy;
    end
    chk("busy_hold", 32'(seen), 32'd0);
    serve(1);
    rv = '0;

    // frame_tick coinciding with busy rise after 3 ticks: no timeout.
    rv = 3'b001;
    launch_to_wait(0);
    rv = '0;
    ftick(); ftick(); ftick();
    x = 10'd639; y = 10'd480; busy = 1'b1;
    tick();
    chk("race_no_err", 32'(err), 32'd0);
    finish_frame(0);

    // Launch timeout after 4 frame_ticks without busy.
    rv = 3'b100;
    launch_to_wait(2);
    rv = '0;
    d0 = done_cnt;
    ftick(); ftick(); ftick();
    chk("timeout_pre", 32'(err), 32'd0);
    ftick();
    chk("timeout_set", 32'(err), 32'd1);
    chk("timeout_no_done", 32'(done_cnt - d0), 32'd0);
    rv = 3'b001;
    serve(0);
    rv = '0;
    chk("timeout_sticky", 32'(err), 32'd1);

    // Reset while streaming.
    rv = 3'b010;
    launch_to_wait(1);
    busy = 1'b1; y = 10'd0;
    tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_ready", 32'(rdy), 32'd0);
    chk("rst_mid_fc", 32'(fc), 32'd0);
    chk("rst_mid_err", 32'(err), 32'd0);
    chk("rst_mid_gen_data", 32'(gd == '0), 32'd1);
    rst = 1'b0; busy = 1'b0; rv = 3'b111;
    serve(0);
    rv = '0;
    chk("rst_mid_fc_after", 32'(fc), 32'd1);

`ifdef PIXEL_SCHED_KEEPALIVE_EN
    rst = 1'b1; tick(); rst = 1'b0; tick();
    gwe_cnt = 0;
    d0 = done_cnt;
    for (int i = 0; i < 8; i++) ftick();
    chk("ka_not_early", 32'(gwe_cnt), 32'd0);
    x = 10'd0; y = 10'd481;
    tick();
    chk("ka_gwe", 32'(gwe), 32'd1);
    chk("ka_no_gda", 32'(gda), 32'd0);
    tick();
    busy = 1'b1; y = 10'd0;
    tick();
    busy = 1'b0;
    tick();
    tick();
    chk("ka_no_done", 32'(done_cnt - d0), 32'd0);
    chk("ka_fc", 32'(fc), 32'd0);
    chk("ka_single", 32'(gwe_cnt), 32'd1);
`else
    chk("no_gwe", 32'(gwe_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pixel_frame_scheduler.md
Name: pixel_frame_scheduler

Overview:
- Shares the single MIPI pixel payload generator between NREQ payload requesters (mining job, nonce result, status).
- Arbitrates round-robin and latches the winner's payload into a stable register.
- Launches the generator only in vertical blanking, so each payload starts on a frame's first header pixel.
- Tracks generator busy through the frame and reports completion and timeouts back to the requester.

Parameters:
- DLEN, 43, payload length in bytes; must equal the generator's DLEN.
- NREQ, 3, number of requesters (2..8).
- activeVideo_h, 640, active pixels per line.
- activeVideo_v, 480, active lines per frame.
- TIMEOUT_FRAMES, 4, frames allowed between launch and generator busy rising.
- KEEPALIVE_FRAMES, 8, idle frames before an empty keep-alive frame (only with feature).

Ports:
- tx_pixel_clk  in  1  pixel clock; sole clock.
- rst  in  1  reset; synchronous, active-high.
- x  in  10  current pixel column from the timing generator.
- y  in  10  current line from the timing generator.
- req_valid  in  NREQ  per-requester payload pending.
- req_data  in  NREQ*DLEN*8  payloads; requester i occupies bits [i*DLEN*8 +: DLEN*8].
- req_ready  out  NREQ  one-cycle accept pulse; payload has been latched.
- req_done  out  NREQ  one-cycle pulse when that requester's frame has finished.
- gen_busy  in  1  generator busy.
- gen_data  out  DLEN*8  latched payload to the generator.
- gen_data_available  out  1  one-cycle launch pulse (payload frame).
- gen_write_enable  out  1  one-cycle launch pulse (empty frame).
- frame_count  out  16  completed payload frames, wraps at 0xFFFF->0.
- err_timeout  out  1  sticky; set on launch timeout; cleared only by rst.

Behaviour:
- Reset values:
  - All outputs 0, gen_data 0.
  - State IDLE.
  - Round-robin pointer = NREQ-1, so requester 0 wins first.
  - Timeout and idle counters 0.
- frame_tick is a combinational strobe: x==activeVideo_h-1 && y==activeVideo_v. This is the generator's end-of-data point.
- Launch window is y>=activeVideo_v (blanking).
- IDLE:
  - Move to GRANT when any req_valid is set, gen_busy==0 and the launch window is open.
  - Winner = first set req_valid at index (ptr+1 .. ptr+NREQ) mod NREQ.
  - req_valid is sampled only in IDLE; dropping it earlier means no grant.
- GRANT (1 cycle):
  - gen_data <= winner's slice; req_ready[winner] pulses.
  - Store winner index; ptr <= winner.
  - Go to LAUNCH.
- LAUNCH (1 cycle): gen_data_available=1; clear timeout counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - On gen_busy==1, go to STREAM.
  - Each frame_tick increments the timeout counter.
  - When the counter reaches TIMEOUT_FRAMES, set err_timeout and go to IDLE. No req_done is given; the requester may re-request.
- STREAM:
  - On gen_busy==0, go to DONE.
  - gen_data holds constant for the whole frame; new req_valid is ignored.
- DONE (1 cycle):
  - req_done[winner] pulses; frame_count increments.
  - Go to IDLE. The next launch waits for the next blanking window at the earliest.
- Latencies:
  - Request in IDLE with the window open: req_ready 1 cycle later, gen_data_available 2 cycles later.
  - DONE: 1 cycle after busy falls.
- Boundary conditions:
  - gen_busy already high in IDLE: hold in IDLE.
  - Simultaneous requests: round-robin order, no starvation.
  - frame_tick together with a busy rise in WAIT_BUSY: busy wins and the counter does not matter.
  - rst mid-frame: immediate return to IDLE with outputs zeroed. The generator is expected to be reset by the same rst.

Optional Feature:
- Macro: PIXEL_SCHED_KEEPALIVE_EN.
- With the macro:
  - An idle counter increments on each frame_tick while in IDLE with no req_valid; any grant or keep-alive clears it.
  - At KEEPALIVE_FRAMES, in the next open window, issue one gen_write_enable pulse and enter WAIT_BUSY/STREAM with no winner.
  - DONE for a keep-alive frame gives no req_done and no frame_count increment.
- Without the macro: gen_write_enable is tied to 0 and there is no idle counter.

Decomposition:
- Package pixel_sched_pkg holds:
  - The state enum (IDLE, GRANT, LAUNCH, WAIT_BUSY, STREAM, DONE).
  - The frame_tick and launch-window predicates as functions of x, y, activeVideo_h, activeVideo_v.
  - Shared SOF/EOF constants 16'hEAFF and 16'hDDAA.
- One sub-module, pixel_rr_arbiter: NREQ request vector plus pointer in, one-hot grant plus index out; purely combinational.

Test Plan:
- Single request: req_valid=3'b001 at y=480 -> req_ready=001 next cycle; gen_data_available pulses 2 cycles after request; gen_data equals slice 0; drive busy high for one frame, then low -> req_done=001 one cycle later; frame_count=1.
- Contention: req_valid=3'b111 held for 3 frames -> grant order 0,1,2; each req_ready pulse falls in a different blanking window.
- Mid-frame request: req_valid rises at y=100 -> no req_ready until y=480.
- Timeout: launch, keep gen_busy low for 4 frame_ticks -> err_timeout=1, back in IDLE, no req_done; err_timeout stays 1 after the next successful frame.
- Reset in STREAM: assert rst for 1 cycle -> all outputs 0; next request goes to requester 0.
- PIXEL_SCHED_KEEPALIVE_EN defined, no requests for 8 frames -> one gen_write_enable pulse in blanking; frame_count unchanged; no req_done.
